vip_hist_equ_clahe: RTL and testbench

Global histogram-equalisation stage for the VIP pixel pipeline. It adds a runtime contrast-limit (clip) value and a bypass enable. Histograms are ping-pong banked, and the lookup map is double-buffered, so a new map never goes live mid-frame. Frame size is not a parameter: the clipped pixel total is measured per frame and normalised with an iterative divider. The block sits between the demosaic/CSC luma output and the LCD/SDRAM writer.

---
 rtl/vip_hist_equ_clahe.sv | 232 +++++++++++++++++++++++
 tb/tb_vip_hist_equ_clahe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vip_hist_equ_clahe.sv
// Global histogram equalisation with per-bin clip, ping-pong histogram banks
// and a double-buffered lookup map that only changes at a frame boundary.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zero both histogram banks after reset, pixels ignored
// ST_IDLE  | waiting for a vsync rising edge to start a build
// ST_SUM   | clipped total T over the retired bank
// ST_DIV   | restoring divide S = (2^BITS-1)*2^HIST_BITS / T
// ST_MAP   | running cdf, write shadow map, zero the retired bank
module vip_hist_equ_clahe #(
    parameter int BITS      = 8,
    parameter int HIST_BITS = 20
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 in_href,
    input  logic                 in_vsync,
    input  logic [BITS-1:0]      in_data,
    input  logic                 cfg_enable,
    input  logic [HIST_BITS-1:0] cfg_clip,
    output logic                 out_href,
    output logic                 out_vsync,
    output logic [BITS-1:0]      out_data,
    output logic                 out_map_valid,
    output logic                 out_busy,
    output logic                 out_overrun
);

    localparam int NB = 1 << BITS;
    localparam int QW = BITS + HIST_BITS;
    localparam int PW = 2 * HIST_BITS + BITS;
    localparam int CW = BITS + 2;

    localparam logic [CW-1:0] K1     = CW'(1);
    localparam logic [CW-1:0] K2     = CW'(2);
    localparam logic [CW-1:0] K3     = CW'(3);
    localparam logic [CW-1:0] K_NBM1 = CW'(NB - 1);
    localparam logic [CW-1:0] K_NB   = CW'(NB);
    localparam logic [CW-1:0] K_NB1  = CW'(NB + 1);
    localparam logic [CW-1:0] K_NB2  = CW'(NB + 2);
    localparam logic [CW-1:0] K_QM1  = CW'(QW - 1);
    localparam logic [QW-1:0] DIVIDEND = {{BITS{1'b1}}, {HIST_BITS{1'b0}}};

    typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_SUM, ST_DIV, ST_MAP} state_t;

    logic [HIST_BITS-1:0] hist_mem [2][NB];
    logic [BITS-1:0]      map_mem  [2][NB];

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 act_q, bld_q, live_q, pend_q, en_q;
    logic [HIST_BITS-1:0] clip_q, tot_q, cdf_q, c_q, rem_q;
    logic [QW-1:0]        quo_q;
    logic [HIST_BITS-1:0] rd_bld_q, rd_acc_q;

    logic                 a_v_q, a_bank_q, w_v_q, w_bank_q;
    logic [BITS-1:0]      a_addr_q, w_addr_q;
    logic [HIST_BITS-1:0] w_data_q;

    logic                 vs_rise;
    logic                 fwd_d;
    logic [HIST_BITS-1:0] base_d, inc_d, clip_d, rem_d;
    logic [HIST_BITS:0]   trial_d;
    logic                 ge_d;
    logic [PW-1:0]        prod_d, shr_d;
    logic [BITS-1:0]      map_d, map_idx_d, idx_d;

    function automatic logic [HIST_BITS-1:0] sat_add(input logic [HIST_BITS-1:0] a,
                                                     input logic [HIST_BITS-1:0] b);
        logic [HIST_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[HIST_BITS] ? {HIST_BITS{1'b1}} : s[HIST_BITS-1:0];
    endfunction

    assign vs_rise  = in_vsync & ~out_vsync;
    assign out_busy = (state_q != ST_IDLE);
    assign idx_d    = cnt_q[BITS-1:0];

    // A pixel written last cycle has not landed in the bank yet: forward it.
    assign fwd_d  = w_v_q && (w_bank_q == a_bank_q) && (w_addr_q == a_addr_q);
    assign base_d = fwd_d ? w_data_q : rd_acc_q;
    assign inc_d  = (&base_d) ? base_d : base_d + HIST_BITS'(1);

    assign clip_d = ((clip_q != '0) && (rd_bld_q > clip_q)) ? clip_q : rd_bld_q;

    assign trial_d = {rem_q, quo_q[QW-1]};
    assign ge_d    = trial_d >= {1'b0, tot_q};
    assign rem_d   = ge_d ? HIST_BITS'(trial_d - {1'b0, tot_q}) : HIST_BITS'(trial_d);

    assign prod_d    = PW'(cdf_q) * PW'(quo_q);
    assign shr_d     = prod_d >> HIST_BITS;
    assign map_d     = (|shr_d[PW-1:BITS]) ? {BITS{1'b1}} : shr_d[BITS-1:0];
    assign map_idx_d = BITS'(cnt_q - K3);

    always_ff @(posedge pclk) begin
        rd_acc_q <= hist_mem[act_q][in_data];
        rd_bld_q <= hist_mem[bld_q][idx_d];
        if (rst_n) begin
            if (state_q == ST_CLEAR) begin
                hist_mem[0][idx_d] <= '0;
                hist_mem[1][idx_d] <= '0;
            end
            if (state_q == ST_MAP && cnt_q < K_NB)
                hist_mem[bld_q][idx_d] <= '0;
            if (a_v_q)
                hist_mem[a_bank_q][a_addr_q] <= inc_d;
            if (state_q == ST_MAP && cnt_q >= K3 && cnt_q <= K_NB2)
                map_mem[~live_q][map_idx_d] <= map_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q       <= ST_CLEAR;
            cnt_q         <= '0;
            act_q         <= 1'b0;
            bld_q         <= 1'b1;
            live_q        <= 1'b0;
            pend_q        <= 1'b0;
            en_q          <= 1'b0;
            clip_q        <= '0;
            tot_q         <= '0;
            cdf_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            out_map_valid <= 1'b0;
            out_overrun   <= 1'b0;
        end else begin
            out_overrun <= 1'b0;
            if (vs_rise) begin
                if (state_q == ST_IDLE) begin
                    act_q  <= ~act_q;
                    bld_q  <= act_q;
                    en_q   <= cfg_enable;
                    clip_q <= cfg_clip;
                    if (pend_q) begin
                        live_q        <= ~live_q;
                        out_map_valid <= 1'b1;
                    end
                    pend_q  <= 1'b0;
                    state_q <= ST_SUM;
                    cnt_q   <= '0;
                    tot_q   <= '0;
                end else begin
                    out_overrun <= 1'b1;
                end
            end
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + K1;
                    if (cnt_q == K_NBM1) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                end
                ST_SUM: begin
                    cnt_q <= cnt_q + K1;
                    if (cnt_q >= K2)
                        tot_q <= sat_add(tot_q, c_q);
                    if (cnt_q == K_NB1) begin
                        state_q <= ST_DIV;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= DIVIDEND;
                    end
                end
                ST_DIV: begin
                    if (tot_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= {quo_q[QW-2:0], ge_d};
                        cnt_q <= cnt_q + K1;
                        if (cnt_q == K_QM1) begin
                            state_q <= ST_MAP;
                            cnt_q   <= '0;
                            cdf_q   <= '0;
                        end
                    end
                end
                ST_MAP: begin
                    cnt_q <= cnt_q + K1;
                    if (cnt_q >= K2 && cnt_q <= K_NB1)
                        cdf_q <= sat_add(cdf_q, c_q);
                    if (cnt_q == K_NB2) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        pend_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        c_q <= clip_d;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            a_v_q     <= 1'b0;
            a_bank_q  <= 1'b0;
            a_addr_q  <= '0;
            w_v_q     <= 1'b0;
            w_bank_q  <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            out_href  <= 1'b0;
            out_vsync <= 1'b0;
            out_data  <= '0;
        end else begin
            a_v_q     <= in_href && (state_q != ST_CLEAR);
            a_bank_q  <= act_q;
            a_addr_q  <= in_data;
            w_v_q     <= a_v_q;
            w_bank_q  <= a_bank_q;
            w_addr_q  <= a_addr_q;
            w_data_q  <= inc_d;
            out_href  <= in_href;
            out_vsync <= in_vsync;
            if (!in_href)
                out_data <= '0;
            else if (en_q && out_map_valid)
                out_data <= map_mem[live_q][in_data];
            else
                out_data <= in_data;
        end
    end

endmodule

// File: tb/tb_vip_hist_equ_clahe.sv
// Scoreboard bench for vip_hist_equ_clahe: expected pixels are queued when
// driven and compared when out_href appears.
module tb_vip_hist_equ_clahe;

    logic        pclk = 1'b0;
    logic        rst_n, in_href, in_vsync, cfg_enable;
    logic [7:0]  in_data;
    logic [19:0] cfg_clip;
    logic        out_href, out_vsync, out_map_valid, out_busy, out_overrun;
    logic [7:0]  out_data;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ov_cnt   = 0;
    bit          mon_en   = 1'b0;
    logic [7:0]  exp_q[$];

    always #5 pclk = ~pclk;

    vip_hist_equ_clahe #(.BITS(8), .HIST_BITS(20)) dut (
        .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync),
        .in_data(in_data), .cfg_enable(cfg_enable), .cfg_clip(cfg_clip),
        .out_href(out_href), .out_vsync(out_vsync), .out_data(out_data),
        .out_map_valid(out_map_valid), .out_busy(out_busy), .out_overrun(out_overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        if (mon_en) begin
            if (out_href) begin
                if (exp_q.size() == 0)
                    check_eq("sb_nonempty", 32'(exp_q.size()), 32'd1);
                else
                    check_eq("pixel", 32'(out_data), 32'(exp_q.pop_front()));
            end else begin
                check_eq("idle_data", 32'(out_data), 32'd0);
            end
            if (out_overrun)
                ov_cnt++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic px(input logic [7:0] p, input logic [7:0] e);
        @(posedge pclk); #1;
        in_href = 1'b1;
        in_data = p;
        exp_q.push_back(e);
    endtask

    task automatic px_end();
        @(posedge pclk); #1;
        in_href = 1'b0;
        in_data = '0;
        repeat (3) @(posedge pclk);
        #1;
    endtask

    task automatic vs_edge(input bit ov_exp, input int gap);
        @(posedge pclk); #1;
        in_vsync = 1'b1;
        @(posedge pclk); #1;
        in_vsync = 1'b0;
        @(negedge pclk);
        check_eq("out_vsync", 32'(out_vsync), 32'd1);
        check_eq("overrun", 32'(out_overrun), 32'(ov_exp));
        repeat (gap) @(posedge pclk);
        #1;
    endtask

    task automatic wait_clear();
        repeat (10) @(posedge pclk);
        #1;
        check_eq("busy_in_clear", 32'(out_busy), 32'd1);
        repeat (247) @(posedge pclk);
        #1;
        check_eq("busy_after_clear", 32'(out_busy), 32'd0);
        check_eq("valid_after_clear", 32'(out_map_valid), 32'd0);
    endtask

    // 64x100 frame, then frame 2, then a ramp that must land on 0/255.
    task automatic run_basic(input bit flat2);
        vs_edge(1'b0, 600);
        repeat (64) px(8'd100, 8'd100);
        px_end();
        vs_edge(1'b0, 600);
        check_eq("valid_f2", 32'(out_map_valid), 32'd0);
        if (flat2) begin
            repeat (64) px(8'd100, 8'd100);
        end else begin
            for (int i = 0; i < 256; i++) px(8'(i), 8'(i));
        end
        px_end();
        vs_edge(1'b0, 600);
        check_eq("valid_f3", 32'(out_map_valid), 32'd1);
        for (int i = 0; i < 256; i++) px(8'(i), (i < 100) ? 8'd0 : 8'd255);
        px_end();
    endtask

    initial begin
        rst_n      = 1'b0;
        in_href    = 1'b0;
        in_vsync   = 1'b0;
        in_data    = '0;
        cfg_enable = 1'b1;
        cfg_clip   = '0;
        repeat (3) @(posedge pclk);
        #1;
        mon_en = 1'b1;
        @(negedge pclk);
        check_eq("rst_busy", 32'(out_busy), 32'd1);
        check_eq("rst_valid", 32'(out_map_valid), 32'd0);
        check_eq("rst_overrun", 32'(out_overrun), 32'd0);
        check_eq("rst_href", 32'(out_href), 32'd0);
        check_eq("rst_vsync", 32'(out_vsync), 32'd0);
        @(posedge pclk); #1;
        rst_n = 1'b1;
        wait_clear();

        // E1..E3: identity, then map from 64x100
        run_basic(1'b0);

        // E4: ramp map is identity; frame 4 = 32x0 + 32x255
        vs_edge(1'b0, 600);
        repeat (32) px(8'd0, 8'd0);
        repeat (32) px(8'd255, 8'd255);
        px_end();

        // E5: frame 5 = 60x10 + 4x200, built with clip 4 at E6
        vs_edge(1'b0, 600);
        repeat (60) px(8'd10, 8'd10);
        repeat (4) px(8'd200, 8'd200);
        px_end();
        cfg_clip = 20'd4;

        // E6: 32/32 map live
        vs_edge(1'b0, 600);
        px(8'd0, 8'd127); px(8'd100, 8'd127); px(8'd254, 8'd127); px(8'd255, 8'd255);
        px_end();

        // E7: clipped map live (T = 8)
        vs_edge(1'b0, 600);
        px(8'd0, 8'd0); px(8'd5, 8'd0); px(8'd10, 8'd127);
        px(8'd150, 8'd127); px(8'd200, 8'd255); px(8'd255, 8'd255);
        px_end();
        cfg_clip = 20'd0;

        // E8 then E9 only ~100 cycles later: overrun, frames merge
        vs_edge(1'b0, 5);
        repeat (4) px(8'd50, 8'd63);
        px_end();
        repeat (80) @(posedge pclk);
        #1;
        check_eq("busy_before_ovr", 32'(out_busy), 32'd1);
        vs_edge(1'b1, 5);
        check_eq("ovr_count", 32'(ov_cnt), 32'd1);
        repeat (4) px(8'd150, 8'd127);
        px_end();
        repeat (600) @(posedge pclk);
        #1;

        // E10: map from frame 7 live (T = 6)
        vs_edge(1'b0, 600);
        px(8'd0, 8'd42); px(8'd4, 8'd42); px(8'd5, 8'd85); px(8'd7, 8'd85);
        px(8'd10, 8'd127); px(8'd149, 8'd127); px(8'd150, 8'd170);
        px(8'd200, 8'd212); px(8'd254, 8'd212); px(8'd255, 8'd255);
        px_end();

        // E11: map from merged 4x50 + 4x150
        vs_edge(1'b0, 600);
        px(8'd0, 8'd0); px(8'd49, 8'd0); px(8'd50, 8'd127);
        px(8'd149, 8'd127); px(8'd150, 8'd255); px(8'd255, 8'd255);
        px_end();

        // E12: reset during MAP, then replay
        vs_edge(1'b0, 400);
        check_eq("busy_in_map", 32'(out_busy), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check_eq("rst2_busy", 32'(out_busy), 32'd1);
        check_eq("rst2_valid", 32'(out_map_valid), 32'd0);
        @(posedge pclk); #1;
        rst_n = 1'b1;
        wait_clear();
        run_basic(1'b1);

        // passthrough with a non-identity map live
        cfg_enable = 1'b0;
        vs_edge(1'b0, 600);
        check_eq("valid_bypass", 32'(out_map_valid), 32'd1);
        for (int i = 0; i < 256; i++) px(8'(i), 8'(i));
        px_end();

        repeat (5) @(posedge pclk);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        check_eq("ovr_total", 32'(ov_cnt), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
